sr_latch_driver: RTL

Clocked initiator that drives a NOR-based RS latch's `set`/`reset` inputs from a simple command handshake and confirms the latch's `q`/`q_bar` response. It sits between synchronous control logic and an asynchronous RS latch cell. It guarantees:
- `set` and `reset` are never asserted together.
- Every pulse has a fixed width.
- Each command completes with either a `done` or an `err` pulse after feedback check or timeout.

---
 rtl/sr_latch_driver.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//   Clocked initiator for a NOR-based RS latch. Accepts a one-bit command
//   through a valid/ready handshake. If the latch already holds the target,
//   it confirms at once. Otherwise it drives a fixed-width pulse on set or
//   reset, then watches the latch feedback until it matches or a timeout
//   expires. Every command ends with a one-cycle done or err pulse.
//
//   Build option SR_DRV_SYNC_EN:
//     defined   - q_fb/q_bar_fb pass through a 2-flop synchronizer (2-cycle lag)
//     undefined - q_fb/q_bar_fb pass through a single register stage (1-cycle lag)
//
//   Parameters
//     PULSE_W  : cycles set/reset is held high (1..255)
//     TIMEOUT  : maximum WAIT cycles before err (1..255)
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     cmd_valid  in   command request
//     cmd_val    in   target latch state (1 = set, 0 = reset)
//     cmd_ready  out  driver idle; command accepted on cmd_valid & cmd_ready
//     set        out  registered drive to latch set input
//     reset      out  registered drive to latch reset input
//     q_fb       in   latch q (asynchronous)
//     q_bar_fb   in   latch q_bar (asynchronous)
//     done       out  one-cycle pulse, command confirmed
//     err        out  one-cycle pulse, command failed
//     err_code   out  valid with err: 01 stuck at wrong value, 10 q == q_bar
module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_val,
  output logic       cmd_ready,
  output logic       set,
  output logic       reset,
  input  logic       q_fb,
  input  logic       q_bar_fb,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [7:0] PW_LD = 8'(PULSE_W);
  localparam logic [7:0] TO_LD = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, RESP} state_t;

  logic qs, qbs;

  // feedback input stage
`ifdef SR_DRV_SYNC_EN
  logic q_p0, qb_p0, q_p1, qb_p1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p0  <= 1'b0;
      qb_p0 <= 1'b0;
      q_p1  <= 1'b0;
      qb_p1 <= 1'b0;
    end else begin
      q_p0  <= q_fb;
      qb_p0 <= q_bar_fb;
      q_p1  <= q_p0;
      qb_p1 <= qb_p0;
    end
  end
  assign qs  = q_p1;
  assign qbs = qb_p1;
`else
  logic q_p0, qb_p0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p0  <= 1'b0;
      qb_p0 <= 1'b0;
    end else begin
      q_p0  <= q_fb;
      qb_p0 <= q_bar_fb;
    end
  end
  assign qs  = q_p0;
  assign qbs = qb_p0;
`endif

  state_t     state, nstate;
  logic [7:0] cnt, ncnt;
  logic       tgt, ntgt;
  logic       ndone, nerr;
  logic [1:0] ncode;
  logic       match, match_acc;

  assign match     = (qs == tgt) & (qbs == ~tgt);
  // at accept tgt is not yet loaded, so compare against the incoming value
  assign match_acc = (qs == cmd_val) & (qbs == ~cmd_val);

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    ntgt   = tgt;
    ndone  = 1'b0;
    nerr   = 1'b0;
    ncode  = 2'b00;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          ntgt = cmd_val;
          if (match_acc) begin
            nstate = RESP;
            ndone  = 1'b1;
          end else begin
            nstate = PULSE;
            ncnt   = PW_LD;
          end
        end
      end
      PULSE: begin
        if (cnt == 8'd1) begin
          nstate = WAIT;
          ncnt   = TO_LD;
        end else begin
          ncnt = cnt - 8'd1;
        end
      end
      WAIT: begin
        if (match) begin
          nstate = RESP;
          ndone  = 1'b1;
          ncnt   = 8'd0;
        end else if (cnt == 8'd1) begin
          nstate = RESP;
          nerr   = 1'b1;
          ncode  = (qs == qbs) ? 2'b10 : 2'b01;
          ncnt   = 8'd0;
        end else begin
          ncnt = cnt - 8'd1;
        end
      end
      RESP: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  // state register; outputs registered from next-state so set/reset never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      tgt       <= 1'b0;
      cmd_ready <= 1'b1;
      set       <= 1'b0;
      reset     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= nstate;
      cnt       <= ncnt;
      tgt       <= ntgt;
      cmd_ready <= (nstate == IDLE);
      set       <= (nstate == PULSE) &  ntgt;
      reset     <= (nstate == PULSE) & ~ntgt;
      done      <= ndone;
      err       <= nerr;
      err_code  <= ncode;
    end
  end

endmodule
